// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the datapath and the hazard controller.
//   master : datapath side. Drives the D/E/M/W register addresses, the
//            write enables, loadE and PCSrcE. Receives the stall, flush and
//            forward controls and the perf counters.
//   slave  : hazard_ctrl side. The directions are the mirror of master.
interface hazard_ctrl_if #(
   parameter int ADW   = 5,
   parameter int CNT_W = 16
);
   logic [ADW-1:0]   Rs1D, Rs2D, Rs1E, Rs2E;
   logic [ADW-1:0]   RdE, RdM, RdW;
   logic             regwriteE, regwriteM, regwriteW;
   logic             loadE, PCSrcE;
   logic             stallF, stallD, flushD, flushE;
   logic [1:0]       fwdAE, fwdBE;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             regwriteE, regwriteM, regwriteW, loadE, PCSrcE,
      input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, stall_cnt, flush_cnt
   );
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
             regwriteE, regwriteM, regwriteW, loadE, PCSrcE,
      output stallF, stallD, flushD, flushE, fwdAE, fwdBE, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for the rv32i 5-stage core.
//   clk, rst_n : clock and synchronous active-low reset
//   hz (slave) : D/E/M/W register addresses, write enables, loadE and PCSrcE
//                come in. stallF/stallD, flushD/flushE, fwdAE/fwdBE and the
//                saturating stall_cnt/flush_cnt go out.
// Every control output is combinational from the inputs and the stall
// countdown, so a hazard is acted on in the cycle it is seen.

// Per-operand E-stage forward select. M has priority over W.
module hazard_fwd_sel #(
   parameter int ADW    = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic [ADW-1:0] rsE,
   input  logic [ADW-1:0] RdM,
   input  logic [ADW-1:0] RdW,
   input  logic           regwriteM,
   input  logic           regwriteW,
   output logic [1:0]     fwd
);
   logic matchM, matchW;

   always_comb begin
      matchM = regwriteM && (RdM == rsE) && (rsE != '0);
      matchW = regwriteW && (RdW == rsE) && (rsE != '0);
      fwd    = 2'b00;
      if (FWD_EN) begin
         if (matchM)      fwd = 2'b10;
         else if (matchW) fwd = 2'b01;
      end
   end
endmodule

module hazard_ctrl #(
   parameter int ADW      = 5,
   parameter bit FWD_EN   = 1'b1,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          rst_n,
   hazard_ctrl_if.slave hz
);
   localparam int NOPS = 2;

   logic [NOPS-1:0][ADW-1:0] rsE;
   logic [NOPS-1:0][1:0]     fwd;

   assign rsE = {hz.Rs2E, hz.Rs1E};

   for (genvar i = 0; i < NOPS; i++) begin : gOp
      hazard_fwd_sel #(.ADW(ADW), .FWD_EN(FWD_EN)) uFwd (
         .rsE       (rsE[i]),
         .RdM       (hz.RdM),
         .RdW       (hz.RdW),
         .regwriteM (hz.regwriteM),
         .regwriteW (hz.regwriteW),
         .fwd       (fwd[i])
      );
   end

   logic [1:0]       cnt;
   logic [1:0]       nLen;
   logic             mE, mM, need, hzNow, stall;
   logic [CNT_W-1:0] stallCnt, flushCnt;

   function automatic logic match(input logic we, input logic [ADW-1:0] rd,
                                  input logic [ADW-1:0] s);
      return we && (rd == s) && (s != '0);
   endfunction

   always_comb begin
      mE = match(hz.regwriteE, hz.RdE, hz.Rs1D) || match(hz.regwriteE, hz.RdE, hz.Rs2D);
      mM = match(hz.regwriteM, hz.RdM, hz.Rs1D) || match(hz.regwriteM, hz.RdM, hz.Rs2D);
      if (FWD_EN) begin
         need = hz.loadE && mE;
         nLen = 2'(LOAD_LAT);
      end else begin
         // A W-stage producer is never a hazard: the regfile writes early in the cycle.
         need = mE || mM;
         nLen = mE ? 2'd2 : 2'd1;
      end
      // A taken branch makes the D instruction wrong-path, so it kills any stall.
      hzNow = need && (cnt == 2'd0) && !hz.PCSrcE;
      stall = hzNow || ((cnt != 2'd0) && !hz.PCSrcE);
   end

   // cnt holds the remaining stall cycles after the current one.
   always_ff @(posedge clk) begin
      if (!rst_n)             cnt <= 2'd0;
      else if (hz.PCSrcE)     cnt <= 2'd0;
      else if (hzNow)         cnt <= nLen - 2'd1;
      else if (cnt != 2'd0)   cnt <= cnt - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stall && (stallCnt != '1))     stallCnt <= stallCnt + 1'b1;
         if (hz.PCSrcE && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
      end
   end

   always_comb begin
      hz.stallF    = 1'b0;
      hz.stallD    = 1'b0;
      hz.flushD    = 1'b1;
      hz.flushE    = 1'b1;
      hz.fwdAE     = 2'b00;
      hz.fwdBE     = 2'b00;
      hz.stall_cnt = stallCnt;
      hz.flush_cnt = flushCnt;
      if (rst_n) begin
         hz.stallF = stall;
         hz.stallD = stall;
         hz.flushD = hz.PCSrcE;
         hz.flushE = stall || hz.PCSrcE;
         hz.fwdAE  = fwd[0];
         hz.fwdBE  = fwd[1];
      end
   end
endmodule
